// File: rtl/exe_muldiv.sv
// Iterative RV64M multiply/divide unit: one bit per cycle, shift-add multiply,
// restoring divide, single-cycle shortcut for divide-by-zero, signed overflow
// and illegal word-sized high multiplies.
module exe_muldiv #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_funct3,
  input  logic             in_w,
  input  logic [XLEN-1:0]  in_op1,
  input  logic [XLEN-1:0]  in_op2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_data,
  output logic [TAG_W-1:0] out_tag
);

  localparam int unsigned CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [2*XLEN-1:0] mcand_q, mcand_d;
  logic [XLEN-1:0]   opb_q, opb_d;
  logic [2:0]        f3_q, f3_d;
  logic              w_q, w_d;
  logic              s1_q, s1_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   out_data_q, out_data_d;
  logic [TAG_W-1:0]  out_tag_q, out_tag_d;

  function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] x);
    logic signed [XLEN-1:0] t;
    t = $signed(x << (XLEN - 32));
    return XLEN'(t >>> (XLEN - 32));
  endfunction

  function automatic logic [XLEN-1:0] zext32(input logic [XLEN-1:0] x);
    return XLEN'(x[31:0]);
  endfunction

  // Operand decode for a new request: extension, signs, magnitudes, shortcuts.
  logic            sgn1, sgn2, s1, s2, div0, ovf, illegal, fast;
  logic [XLEN-1:0] ext1, ext2, abs1, abs2, min_val, fast_raw, fast_res;
  always_comb begin
    sgn1 = (in_funct3 == 3'b001) || (in_funct3 == 3'b010) ||
           (in_funct3 == 3'b100) || (in_funct3 == 3'b110);
    sgn2 = (in_funct3 == 3'b001) || (in_funct3 == 3'b100) || (in_funct3 == 3'b110);
    ext1 = in_op1;
    ext2 = in_op2;
    if (in_w) begin
      ext1 = sgn1 ? sext32(in_op1) : zext32(in_op1);
      ext2 = sgn2 ? sext32(in_op2) : zext32(in_op2);
    end
    s1   = sgn1 && ext1[XLEN-1];
    s2   = sgn2 && ext2[XLEN-1];
    abs1 = s1 ? -ext1 : ext1;
    abs2 = s2 ? -ext2 : ext2;
    min_val = in_w ? sext32(XLEN'(32'h8000_0000)) : {1'b1, {(XLEN-1){1'b0}}};
    div0 = in_funct3[2] && (ext2 == '0);
    ovf  = in_funct3[2] && !in_funct3[0] && (ext1 == min_val) && (ext2 == '1);
    // Word ops do not exist on a 32-bit datapath; they are answered with zero.
    illegal = in_w && ((XLEN == 32) || (!in_funct3[2] && (in_funct3[1:0] != 2'b00)));
    fast = div0 || ovf || illegal;
    fast_raw = '0;
    if (illegal)   fast_raw = '0;
    else if (div0) fast_raw = in_funct3[1] ? ext1 : '1;
    else if (ovf)  fast_raw = in_funct3[1] ? '0 : ext1;
    fast_res = in_w ? sext32(fast_raw) : fast_raw;
  end

  // One iteration of multiply or divide, plus sign correction of the final step.
  logic [2*XLEN-1:0] acc_nxt, prod;
  logic [XLEN:0]     top, diff;
  logic [XLEN-1:0]   quo, rem, res_raw, res;
  logic              last;
  always_comb begin
    top  = acc_q[2*XLEN-1:XLEN-1];
    diff = top - {1'b0, opb_q};
    if (f3_q[2]) begin
      if (!diff[XLEN]) acc_nxt = {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      else             acc_nxt = {top[XLEN-1:0],  acc_q[XLEN-2:0], 1'b0};
    end else begin
      acc_nxt = acc_q + (opb_q[cnt_q] ? mcand_q : '0);
    end
    prod = neg_q ? -acc_nxt : acc_nxt;
    quo  = neg_q ? -acc_nxt[XLEN-1:0] : acc_nxt[XLEN-1:0];
    rem  = s1_q ? -acc_nxt[2*XLEN-1:XLEN] : acc_nxt[2*XLEN-1:XLEN];
    if (f3_q[2])              res_raw = f3_q[1] ? rem : quo;
    else if (f3_q == 3'b000)  res_raw = prod[XLEN-1:0];
    else                      res_raw = prod[2*XLEN-1:XLEN];
    res  = w_q ? sext32(res_raw) : res_raw;
    last = (cnt_q == (w_q ? CW'(31) : CW'(XLEN - 1)));
  end

  // Next-state and register-update logic; flush overrides everything.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    opb_d      = opb_q;
    f3_d       = f3_q;
    w_d        = w_q;
    s1_d       = s1_q;
    neg_d      = neg_q;
    out_data_d = out_data_q;
    out_tag_d  = out_tag_q;
    case (state_q)
      IDLE: begin
        if (in_valid && !flush) begin
          f3_d      = in_funct3;
          w_d       = in_w;
          s1_d      = s1;
          neg_d     = s1 ^ s2;
          opb_d     = abs2;
          cnt_d     = '0;
          out_tag_d = in_tag;
          if (fast) begin
            out_data_d = fast_res;
            state_d    = DONE;
          end else begin
            state_d = BUSY;
            // Word divides pre-align the dividend so its MSB leaves first.
            if (in_funct3[2]) begin
              acc_d   = {{XLEN{1'b0}}, abs1 << (in_w ? (XLEN - 32) : 0)};
              mcand_d = '0;
            end else begin
              acc_d   = '0;
              mcand_d = {{XLEN{1'b0}}, abs1};
            end
          end
        end
      end
      BUSY: begin
        acc_d   = acc_nxt;
        mcand_d = mcand_q << 1;
        cnt_d   = CW'(cnt_q + 1'b1);
        if (last) begin
          out_data_d = res;
          state_d    = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      mcand_q    <= '0;
      opb_q      <= '0;
      f3_q       <= '0;
      w_q        <= 1'b0;
      s1_q       <= 1'b0;
      neg_q      <= 1'b0;
      out_data_q <= '0;
      out_tag_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      mcand_q    <= mcand_d;
      opb_q      <= opb_d;
      f3_q       <= f3_d;
      w_q        <= w_d;
      s1_q       <= s1_d;
      neg_q      <= neg_d;
      out_data_q <= out_data_d;
      out_tag_q  <= out_tag_d;
    end
  end

  assign in_ready  = rst_n && (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_data  = out_data_q;
  assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_exe_muldiv.sv
// Directed bench for exe_muldiv (XLEN=64): arithmetic results, latency,
// backpressure, flush and asynchronous reset.
module tb_exe_muldiv;

  localparam int XLEN  = 64;
  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [2:0]       in_funct3 = '0;
  logic             in_w = 1'b0;
  logic [XLEN-1:0]  in_op1 = '0;
  logic [XLEN-1:0]  in_op2 = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [XLEN-1:0]  out_data;
  logic [TAG_W-1:0] out_tag;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [2:0]  f3;
    logic        w;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int          lat;
    string       name;
  } vec_t;

  always #5 clk = ~clk;

  exe_muldiv #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_funct3 (in_funct3),
    .in_w      (in_w),
    .in_op1    (in_op1),
    .in_op2    (in_op2),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag)
  );

  // Present one op, then wait (bounded) for out_valid; latency counts the accept edge as 1.
  task automatic do_op(input logic [2:0] f3, input logic w, input logic [63:0] a,
                       input logic [63:0] b, input logic [4:0] tag,
                       output logic [63:0] d, output logic [4:0] t, output int lat,
                       output int rdy_busy, output logic rdy_issue);
    @(negedge clk);
    in_funct3 = f3; in_w = w; in_op1 = a; in_op2 = b; in_tag = tag; in_valid = 1'b1;
    rdy_issue = in_ready;
    @(posedge clk); #1;
    in_valid = 1'b0; in_op1 = ~a; in_op2 = ~b; in_tag = ~tag; in_funct3 = ~f3;
    lat = 1; rdy_busy = 0;
    while (!out_valid && lat < 100) begin
      if (in_ready) rdy_busy++;
      @(posedge clk); #1;
      lat++;
    end
    d = out_data; t = out_tag;
  endtask

  task automatic handshake(output logic rdy_after, output logic vld_after);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    rdy_after = in_ready;
    vld_after = out_valid;
  endtask

  task automatic test_reset();
    #2;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    total++; if (out_data !== 64'h0) begin bad++; $display("FAIL reset_data: got %h want 0", out_data); end
    total++; if (out_tag !== 5'h0) begin bad++; $display("FAIL reset_tag: got %h want 0", out_tag); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_mul();
    vec_t v[5];
    logic [63:0] d; logic [4:0] t; int lat, rb; logic ri, ra, va;
    v = '{'{3'b000, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65, "mul_7_m3"},
          '{3'b011, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 65, "mulhu_ones"},
          '{3'b001, 1'b0, '1, '1, 64'h0, 65, "mulh_m1_m1"},
          '{3'b010, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFF, 65, "mulhsu_m1_ones"},
          '{3'b000, 1'b0, 64'h1_0000_0001, 64'h1_0000_0001, 64'h2_0000_0001, 65, "mul_wide"}};
    foreach (v[i]) begin
      do_op(v[i].f3, v[i].w, v[i].a, v[i].b, 5'(i + 1), d, t, lat, rb, ri);
      total++; if (ri !== 1'b1) begin bad++; $display("FAIL %s ready_at_issue: got %b want 1", v[i].name, ri); end
      total++; if (d !== v[i].exp) begin bad++; $display("FAIL %s data: got %h want %h", v[i].name, d, v[i].exp); end
      total++; if (t !== 5'(i + 1)) begin bad++; $display("FAIL %s tag: got %0d want %0d", v[i].name, t, i + 1); end
      total++; if (lat !== v[i].lat) begin bad++; $display("FAIL %s latency: got %0d want %0d", v[i].name, lat, v[i].lat); end
      total++; if (rb !== 0) begin bad++; $display("FAIL %s ready_while_busy: got %0d cycles want 0", v[i].name, rb); end
      handshake(ra, va);
      total++; if (ra !== 1'b1 || va !== 1'b0) begin bad++; $display("FAIL %s after_handshake: got ready=%b valid=%b want 1/0", v[i].name, ra, va); end
    end
  endtask

  task automatic test_div();
    vec_t v[10];
    logic [63:0] d; logic [4:0] t; int lat, rb; logic ri, ra, va;
    v = '{'{3'b100, 1'b0, 64'd100, 64'd0, '1, 1, "div_by_zero"},
          '{3'b111, 1'b0, 64'd100, 64'd0, 64'd100, 1, "remu_by_zero"},
          '{3'b100, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1, "div_overflow"},
          '{3'b110, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h0, 1, "rem_overflow"},
          '{3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65, "div_m7_2"},
          '{3'b110, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65, "rem_m7_2"},
          '{3'b100, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 65, "div_7_m2"},
          '{3'b110, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 65, "rem_7_m2"},
          '{3'b101, 1'b0, 64'd100, 64'd7, 64'd14, 65, "divu_100_7"},
          '{3'b111, 1'b0, '1, 64'd10, 64'd5, 65, "remu_ones_10"}};
    foreach (v[i]) begin
      do_op(v[i].f3, v[i].w, v[i].a, v[i].b, 5'(i + 10), d, t, lat, rb, ri);
      total++; if (d !== v[i].exp) begin bad++; $display("FAIL %s data: got %h want %h", v[i].name, d, v[i].exp); end
      total++; if (t !== 5'(i + 10)) begin bad++; $display("FAIL %s tag: got %0d want %0d", v[i].name, t, i + 10); end
      total++; if (lat !== v[i].lat) begin bad++; $display("FAIL %s latency: got %0d want %0d", v[i].name, lat, v[i].lat); end
      total++; if (rb !== 0) begin bad++; $display("FAIL %s ready_while_busy: got %0d cycles want 0", v[i].name, rb); end
      handshake(ra, va);
      total++; if (ra !== 1'b1 || va !== 1'b0) begin bad++; $display("FAIL %s after_handshake: got ready=%b valid=%b want 1/0", v[i].name, ra, va); end
    end
  endtask

  task automatic test_word();
    vec_t v[10];
    logic [63:0] d; logic [4:0] t; int lat, rb; logic ri, ra, va;
    v = '{'{3'b100, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'hABCD_0000_0000_0002, 64'hFFFF_FFFF_FFFF_FFFD, 33, "divw_m7_2"},
          '{3'b110, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'hABCD_0000_0000_0002, 64'hFFFF_FFFF_FFFF_FFFF, 33, "remw_m7_2"},
          '{3'b101, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 33, "divuw_ones_1"},
          '{3'b000, 1'b1, 64'h1_0000_0003, 64'd2, 64'd6, 33, "mulw_3_2"},
          '{3'b000, 1'b1, 64'h4000_0000, 64'd2, 64'hFFFF_FFFF_8000_0000, 33, "mulw_sext"},
          '{3'b001, 1'b1, 64'd5, 64'd6, 64'h0, 1, "mulhw_illegal"},
          '{3'b011, 1'b1, '1, '1, 64'h0, 1, "mulhuw_illegal"},
          '{3'b100, 1'b1, 64'h5_8000_0000, 64'h7_0000_0000, '1, 1, "divw_by_zero"},
          '{3'b111, 1'b1, 64'h8000_0000, 64'h0, 64'hFFFF_FFFF_8000_0000, 1, "remuw_by_zero"},
          '{3'b100, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1, "divw_overflow"}};
    foreach (v[i]) begin
      do_op(v[i].f3, v[i].w, v[i].a, v[i].b, 5'(i + 20), d, t, lat, rb, ri);
      total++; if (d !== v[i].exp) begin bad++; $display("FAIL %s data: got %h want %h", v[i].name, d, v[i].exp); end
      total++; if (t !== 5'(i + 20)) begin bad++; $display("FAIL %s tag: got %0d want %0d", v[i].name, t, i + 20); end
      total++; if (lat !== v[i].lat) begin bad++; $display("FAIL %s latency: got %0d want %0d", v[i].name, lat, v[i].lat); end
      handshake(ra, va);
      total++; if (ra !== 1'b1 || va !== 1'b0) begin bad++; $display("FAIL %s after_handshake: got ready=%b valid=%b want 1/0", v[i].name, ra, va); end
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] d; logic [4:0] t; int lat, rb; logic ri, ra, va;
    do_op(3'b000, 1'b0, 64'd5, 64'd6, 5'd9, d, t, lat, rb, ri);
    total++; if (d !== 64'd30 || t !== 5'd9) begin bad++; $display("FAIL bp_result: got %h/%0d want 1e/9", d, t); end
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b1 || out_data !== 64'd30 || out_tag !== 5'd9 || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold_%0d: got valid=%b data=%h tag=%0d ready=%b want 1/1e/9/0",
                 c, out_valid, out_data, out_tag, in_ready);
      end
    end
    handshake(ra, va);
    total++; if (ra !== 1'b1 || va !== 1'b0) begin bad++; $display("FAIL bp_release: got ready=%b valid=%b want 1/0", ra, va); end
  endtask

  task automatic test_flush();
    logic [63:0] d; logic [4:0] t; int lat, rb; logic ri;
    int seen;
    @(negedge clk);
    in_funct3 = 3'b000; in_w = 1'b0; in_op1 = 64'd3; in_op2 = 64'd4; in_tag = 5'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (19) @(posedge clk);
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; in_funct3 = 3'b101; in_op1 = 64'd10; in_op2 = 64'd0; in_tag = 5'd7;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL flush_busy: got valid=%b ready=%b want 0/1", out_valid, in_ready); end
    seen = 0;
    for (int c = 0; c < 70; c++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL flush_no_result: got %0d valid cycles want 0", seen); end
    do_op(3'b101, 1'b0, 64'd10, 64'd0, 5'd4, d, t, lat, rb, ri);
    total++; if (d !== '1 || lat !== 1) begin bad++; $display("FAIL flush_setup: got %h lat %0d want all ones lat 1", d, lat); end
    @(negedge clk);
    flush = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_funct3 = 3'b100; in_op1 = 64'd1; in_op2 = 64'd0;
    @(posedge clk); #1;
    flush = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL flush_done: got valid=%b ready=%b want 0/1", out_valid, in_ready); end
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_done_later: got valid=%b want 0", out_valid); end
  endtask

  task automatic test_async_reset();
    logic [63:0] d; logic [4:0] t; int lat, rb; logic ri, ra, va;
    @(negedge clk);
    in_funct3 = 3'b000; in_w = 1'b0; in_op1 = 64'd9; in_op2 = 64'd9; in_tag = 5'd11; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || out_data !== 64'h0 || out_tag !== 5'h0) begin
      bad++; $display("FAIL areset_clear: got valid=%b data=%h tag=%0d want 0/0/0", out_valid, out_data, out_tag);
    end
    #1;
    rst_n = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL areset_release: got ready=%b valid=%b want 1/0", in_ready, out_valid); end
    do_op(3'b101, 1'b0, 64'd10, 64'd3, 5'd17, d, t, lat, rb, ri);
    total++; if (d !== 64'd3) begin bad++; $display("FAIL areset_divu_data: got %h want 3", d); end
    total++; if (t !== 5'd17) begin bad++; $display("FAIL areset_divu_tag: got %0d want 17", t); end
    total++; if (lat !== 65) begin bad++; $display("FAIL areset_divu_latency: got %0d want 65", lat); end
    handshake(ra, va);
    total++; if (ra !== 1'b1) begin bad++; $display("FAIL areset_handshake: got ready=%b want 1", ra); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_word();
    test_backpressure();
    test_flush();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
